// File: rtl/warning_alert_dispatcher.sv
// ============================================================================
// Module   : warning_alert_dispatcher
// Purpose  : Turns controller warning-code changes into queued alerts.
//            Presents one alert at a time with a valid/ack handshake.
//            Drives a severity-dependent buzzer and an overflow flag.
// Options  : WARNING_ESCALATE_EN adds an unacknowledged-alert escalation timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module warning_alert_dispatcher #(
    parameter int DEPTH        = 4,
    parameter int BLINK_CYCLES = 8,
    parameter int ESC_CYCLES   = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [2:0]               warningCode,
    input  logic                     alertAck,
    output logic                     alertValid,
    output logic [2:0]               alertCode,
    output logic [$clog2(DEPTH):0]   pendingCount,
    output logic                     buzzer,
    output logic                     overflow,
    output logic                     escalate
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_BLINK_W = $clog2(BLINK_CYCLES + 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || BLINK_CYCLES < 1 || ESC_CYCLES < 1) begin : g_param_check
        $error("warning_alert_dispatcher: illegal parameter set");
    end

    logic [2:0]           r_prev_code;
    logic [2:0]           r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    state_t               r_state;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink_phase;

    logic w_event;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_blink_wrap;
    logic w_phase_next;
    logic w_esc_next;

    assign w_event = (warningCode != 3'd0) && (warningCode != r_prev_code);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    // The FSM only pops from IDLE, so a full FIFO can still accept when it is idle.
    assign w_pop   = (r_state == ST_IDLE) && !w_empty;
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_drop  = w_event && w_full && !w_pop;

    assign pendingCount = r_count;

    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= warningCode;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev_code <= 3'd0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            overflow    <= 1'b0;
        end else begin
            r_prev_code <= warningCode;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                overflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_blink_wrap = (r_blink_cnt == c_BLINK_W'(BLINK_CYCLES - 1));
    assign w_phase_next = w_blink_wrap ? ~r_blink_phase : r_blink_phase;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            alertValid    <= 1'b0;
            alertCode     <= 3'd0;
            buzzer        <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        alertCode     <= r_mem[r_rd_ptr];
                        alertValid    <= 1'b1;
                        buzzer        <= 1'b1;
                        r_blink_cnt   <= '0;
                        r_blink_phase <= 1'b1;
                        r_state       <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (alertAck) begin
                        alertValid <= 1'b0;
                        buzzer     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        if (w_blink_wrap) begin
                            r_blink_cnt   <= '0;
                            r_blink_phase <= ~r_blink_phase;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 1'b1;
                        end
                        // Severities 4..7 and escalated alerts hold the buzzer on.
                        buzzer <= alertCode[2] | w_esc_next | w_phase_next;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    alertValid <= 1'b0;
                    buzzer     <= 1'b0;
                end
            endcase
        end
    end

`ifdef WARNING_ESCALATE_EN
    localparam int c_ESC_W = $clog2(ESC_CYCLES + 1);

    logic [c_ESC_W-1:0] r_esc_timer;
    logic               r_escalate;
    logic               w_esc_hit;

    assign w_esc_hit  = (r_state == ST_PRESENT) && !alertAck &&
                        (r_esc_timer == c_ESC_W'(ESC_CYCLES - 1));
    assign w_esc_next = r_escalate | w_esc_hit;
    assign escalate   = r_escalate;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_esc_timer <= '0;
            r_escalate  <= 1'b0;
        end else if (r_state != ST_PRESENT || alertAck) begin
            r_esc_timer <= '0;
            r_escalate  <= 1'b0;
        end else if (r_esc_timer != c_ESC_W'(ESC_CYCLES)) begin
            r_esc_timer <= r_esc_timer + 1'b1;
            if (w_esc_hit) begin
                r_escalate <= 1'b1;
            end
        end
    end
`else
    assign w_esc_next = 1'b0;
    assign escalate   = 1'b0;
`endif

endmodule

`default_nettype wire
